// File: rtl/mvm_sequencer.sv
// -----------------------------------------------------------------------------
// mvm_sequencer
//   Drives a single dot-product MAC unit so that it computes y = W*x. One input
//   vector x is captured and then processed one matrix row at a time. Each row
//   is read from a synchronous weight ROM and sent to the MAC with x. The
//   scalar results are gathered into a packed output vector. Only one vector
//   is in flight at a time.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_vector/valid/ready
//                       input vector x (element i at [i*B_CELL_WIDTH +: B_CELL_WIDTH])
//   w_addr, w_data      weight ROM row address out, row data in (1-cycle latency)
//   mac_a/valid/ready   weight row to the MAC
//   mac_b/valid/ready   input vector to the MAC
//   mac_result/valid/ready, mac_error
//                       MAC dot-product result and its overflow flag
//   out_vector/valid/ready, out_error
//                       y (row r at [r*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH])
//                       and the OR of mac_error over all rows
// -----------------------------------------------------------------------------
module mvm_sequencer #(
   parameter int VECTOR_LEN        = 5,
   parameter int ROWS              = 4,
   parameter int A_CELL_WIDTH      = 8,
   parameter int B_CELL_WIDTH      = 8,
   parameter int RESULT_CELL_WIDTH = 8,
   parameter int ADDR_WIDTH        = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]  in_vector,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [ADDR_WIDTH-1:0]               w_addr,
   input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]  w_data,
   output logic [VECTOR_LEN*A_CELL_WIDTH-1:0]  mac_a,
   output logic                                mac_a_valid,
   input  logic                                mac_a_ready,
   output logic [VECTOR_LEN*B_CELL_WIDTH-1:0]  mac_b,
   output logic                                mac_b_valid,
   input  logic                                mac_b_ready,
   input  logic [RESULT_CELL_WIDTH-1:0]        mac_result,
   input  logic                                mac_result_valid,
   output logic                                mac_result_ready,
   input  logic                                mac_error,
   output logic [ROWS*RESULT_CELL_WIDTH-1:0]   out_vector,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_error
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t                              state_q, state_d;
   logic [ADDR_WIDTH-1:0]               row_q, row_d;
   logic [ADDR_WIDTH-1:0]               w_addr_q, w_addr_d;
   logic [VECTOR_LEN*B_CELL_WIDTH-1:0]  x_q, x_d;
   logic [VECTOR_LEN*A_CELL_WIDTH-1:0]  wrow_q, wrow_d;
   logic [ROWS*RESULT_CELL_WIDTH-1:0]   out_vec_q, out_vec_d;
   logic                                out_err_q, out_err_d;
   logic                                a_sent_q, a_sent_d;
   logic                                b_sent_q, b_sent_d;

   logic a_done, b_done, issue_done, res_fire, last_row;

   // A channel counts as complete once it has handshaken in this ISSUE visit,
   // either in an earlier cycle (sent flag) or in the current one.
   assign a_done     = a_sent_q | (mac_a_valid & mac_a_ready);
   assign b_done     = b_sent_q | (mac_b_valid & mac_b_ready);
   assign issue_done = a_done & b_done;
   assign res_fire   = mac_result_valid & mac_result_ready;
   assign last_row   = (row_q == LAST_ROW);

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---- FSM: next-state logic ----
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (in_valid)   state_d = S_FETCH;
         S_FETCH:                   state_d = S_WAIT;
         S_WAIT:                    state_d = S_ISSUE;
         S_ISSUE:   if (issue_done) state_d = S_COLLECT;
         S_COLLECT: if (res_fire)   state_d = last_row ? S_DONE : S_FETCH;
         S_DONE:    if (out_ready)  state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      in_ready         = (state_q == S_IDLE);
      mac_a_valid      = (state_q == S_ISSUE) && !a_sent_q;
      mac_b_valid      = (state_q == S_ISSUE) && !b_sent_q;
      mac_result_ready = (state_q == S_COLLECT);
      out_valid        = (state_q == S_DONE);
   end

   assign w_addr     = w_addr_q;
   assign mac_a      = wrow_q;
   assign mac_b      = x_q;
   assign out_vector = out_vec_q;
   assign out_error  = out_err_q;

   // ---- Datapath next values ----
   always_comb begin
      row_d     = row_q;
      w_addr_d  = w_addr_q;
      x_d       = x_q;
      wrow_d    = wrow_q;
      out_vec_d = out_vec_q;
      out_err_d = out_err_q;
      a_sent_d  = a_sent_q;
      b_sent_d  = b_sent_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d       = in_vector;
               row_d     = '0;
               w_addr_d  = '0;
               out_vec_d = '0;
               out_err_d = 1'b0;
            end
         end
         S_WAIT: wrow_d = w_data;
         S_ISSUE: begin
            // Flags are cleared on exit so the next row starts fresh.
            a_sent_d = issue_done ? 1'b0 : a_done;
            b_sent_d = issue_done ? 1'b0 : b_done;
         end
         S_COLLECT: begin
            if (res_fire) begin
               for (int r = 0; r < ROWS; r++) begin
                  if (row_q == ADDR_WIDTH'(r))
                     out_vec_d[r*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = mac_result;
               end
               out_err_d = out_err_q | mac_error;
               // The address is set up on entry to FETCH so the ROM row is
               // ready to capture in WAIT. The row counter stops at the last row.
               if (!last_row) begin
                  row_d    = row_q + ADDR_WIDTH'(1);
                  w_addr_d = row_q + ADDR_WIDTH'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q     <= '0;
         w_addr_q  <= '0;
         x_q       <= '0;
         wrow_q    <= '0;
         out_vec_q <= '0;
         out_err_q <= 1'b0;
         a_sent_q  <= 1'b0;
         b_sent_q  <= 1'b0;
      end else begin
         row_q     <= row_d;
         w_addr_q  <= w_addr_d;
         x_q       <= x_d;
         wrow_q    <= wrow_d;
         out_vec_q <= out_vec_d;
         out_err_q <= out_err_d;
         a_sent_q  <= a_sent_d;
         b_sent_q  <= b_sent_d;
      end
   end

endmodule

// File: tb/tb_mvm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mvm_sequencer
//   Bench for mvm_sequencer. It contains a synchronous weight ROM, a
//   handshaking MAC model with programmable ready and result delays, and a
//   reference model. The reference model computes y = W*x directly from
//   integer arrays.
// -----------------------------------------------------------------------------
module tb_mvm_sequencer;
   localparam int VL   = 5;
   localparam int ROWS = 4;
   localparam int AWD  = 8;
   localparam int BWD  = 8;
   localparam int RWD  = 8;
   localparam int ADW  = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [VL*BWD-1:0]     in_vector;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADW-1:0]        w_addr;
   logic [VL*AWD-1:0]     w_data;
   logic [VL*AWD-1:0]     mac_a;
   logic                  mac_a_valid;
   logic                  mac_a_ready;
   logic [VL*BWD-1:0]     mac_b;
   logic                  mac_b_valid;
   logic                  mac_b_ready;
   logic [RWD-1:0]        mac_result;
   logic                  mac_result_valid;
   logic                  mac_result_ready;
   logic                  mac_error;
   logic [ROWS*RWD-1:0]   out_vector;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_error;

   always #5 clk = ~clk;

   mvm_sequencer #(
      .VECTOR_LEN(VL), .ROWS(ROWS), .A_CELL_WIDTH(AWD), .B_CELL_WIDTH(BWD),
      .RESULT_CELL_WIDTH(RWD), .ADDR_WIDTH(ADW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_vector(in_vector), .in_valid(in_valid), .in_ready(in_ready),
      .w_addr(w_addr), .w_data(w_data),
      .mac_a(mac_a), .mac_a_valid(mac_a_valid), .mac_a_ready(mac_a_ready),
      .mac_b(mac_b), .mac_b_valid(mac_b_valid), .mac_b_ready(mac_b_ready),
      .mac_result(mac_result), .mac_result_valid(mac_result_valid),
      .mac_result_ready(mac_result_ready), .mac_error(mac_error),
      .out_vector(out_vector), .out_valid(out_valid), .out_ready(out_ready),
      .out_error(out_error)
   );

   // ---------------- weight ROM ----------------
   logic [VL*AWD-1:0] rom [0:(1<<ADW)-1];
   always @(posedge clk) w_data <= rom[w_addr];

   // ---------------- MAC model ----------------
   int a_dly = 0, b_dly = 0, r_dly = 0;
   int a_cnt, b_cnt, r_cnt;
   logic a_got, b_got, a_pend, b_pend;
   logic [VL*AWD-1:0] a_buf, a_prev;
   logic [VL*BWD-1:0] b_buf, b_prev;
   int stab_viol = 0;

   function automatic int dot(input logic [VL*AWD-1:0] a, input logic [VL*BWD-1:0] b);
      int s = 0;
      for (int i = 0; i < VL; i++)
         s += int'($signed(a[i*AWD +: AWD])) * int'($signed(b[i*BWD +: BWD]));
      return s;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mac_a_ready <= 1'b0; mac_b_ready <= 1'b0; mac_result_valid <= 1'b0;
         mac_result <= '0; mac_error <= 1'b0;
         a_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         a_got <= 1'b0; b_got <= 1'b0; a_pend <= 1'b0; b_pend <= 1'b0;
         a_buf <= '0; b_buf <= '0; a_prev <= '0; b_prev <= '0;
      end else begin
         // A pending valid must stay high with unchanged data until accepted.
         if (a_pend && (!mac_a_valid || mac_a !== a_prev)) stab_viol <= stab_viol + 1;
         if (b_pend && (!mac_b_valid || mac_b !== b_prev)) stab_viol <= stab_viol + 1;
         a_pend <= mac_a_valid && !mac_a_ready;
         b_pend <= mac_b_valid && !mac_b_ready;
         a_prev <= mac_a;
         b_prev <= mac_b;

         if (mac_a_valid && mac_a_ready) begin
            a_got <= 1'b1; a_buf <= mac_a; mac_a_ready <= 1'b0; a_cnt <= 0;
         end else if (mac_a_valid && !a_got && !mac_a_ready) begin
            if (a_cnt >= a_dly) mac_a_ready <= 1'b1; else a_cnt <= a_cnt + 1;
         end

         if (mac_b_valid && mac_b_ready) begin
            b_got <= 1'b1; b_buf <= mac_b; mac_b_ready <= 1'b0; b_cnt <= 0;
         end else if (mac_b_valid && !b_got && !mac_b_ready) begin
            if (b_cnt >= b_dly) mac_b_ready <= 1'b1; else b_cnt <= b_cnt + 1;
         end

         if (mac_result_valid && mac_result_ready) begin
            mac_result_valid <= 1'b0; a_got <= 1'b0; b_got <= 1'b0; r_cnt <= 0;
         end else if (a_got && b_got && !mac_result_valid) begin
            if (r_cnt >= r_dly) begin
               mac_result       <= RWD'(dot(a_buf, b_buf));
               mac_error        <= (dot(a_buf, b_buf) > 127) || (dot(a_buf, b_buf) < -128);
               mac_result_valid <= 1'b1;
            end else r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- reference model ----------------
   int Wm [ROWS][VL];
   int xv [VL];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_rom();
      int t;
      for (int r = 0; r < (1 << ADW); r++) rom[r] = '0;
      for (int r = 0; r < ROWS; r++)
         for (int i = 0; i < VL; i++) begin
            t = Wm[r][i];
            rom[r][i*AWD +: AWD] = t[AWD-1:0];
         end
   endtask

   task automatic drive_x();
      int t;
      for (int i = 0; i < VL; i++) begin
         t = xv[i];
         in_vector[i*BWD +: BWD] = t[BWD-1:0];
      end
   endtask

   task automatic expect_y(output logic [ROWS*RWD-1:0] ey, output logic eerr);
      int s;
      ey = '0; eerr = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         s = 0;
         for (int i = 0; i < VL; i++) s += Wm[r][i] * xv[i];
         ey[r*RWD +: RWD] = s[RWD-1:0];
         if (s > 127 || s < -128) eerr = 1'b1;
      end
   endtask

   task automatic set_case1();
      for (int i = 0; i < VL; i++) begin
         xv[i] = i + 1;
         Wm[0][i] = 1; Wm[1][i] = 2; Wm[2][i] = (i == 0) ? 1 : 0; Wm[3][i] = 0;
      end
      load_rom();
   endtask

   // Push one vector through and check y, then hold out_ready low for 'hold' cycles.
   task automatic run_vec(input string tag, input int hold);
      logic [ROWS*RWD-1:0] ey;
      logic eerr;
      int n;
      expect_y(ey, eerr);
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      drive_x();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 2000) begin @(negedge clk); n++; end
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
      chk({tag, "_y"}, 64'(out_vector), 64'(ey));
      chk({tag, "_err"}, 64'(out_error), 64'(eerr));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {out_valid, in_ready, out_error, out_vector},
             {1'b1, 1'b0, eerr, ey});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_release"}, 64'({out_valid, in_ready}), 64'(2'b01));
      chk({tag, "_stable_mac"}, 64'(stab_viol), 64'(0));
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; in_vector = '0; out_ready = 1'b0;
      for (int r = 0; r < (1 << ADW); r++) rom[r] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ctrl",
          64'({in_ready, out_valid, mac_a_valid, mac_b_valid, mac_result_ready}),
          64'(5'b10000));
      chk("reset_waddr", 64'(w_addr), 64'(0));
      chk("reset_out", 64'({out_error, out_vector}), 64'(0));

      // Case 1: basic rows.
      set_case1();
      run_vec("c1", 0);
      chk("c1_const", 64'(out_vector), 64'(32'h00_01_1E_0F));

      // Case 2: negative row, signed packing.
      for (int i = 0; i < VL; i++) Wm[0][i] = -1;
      load_rom();
      run_vec("c2", 1);
      chk("c2_slot0", 64'(out_vector[7:0]), 64'(8'hF1));

      // Case 3: staggered channel readiness.
      set_case1();
      a_dly = 3; b_dly = 6;
      run_vec("c3", 0);
      chk("c3_const", 64'(out_vector), 64'(32'h00_01_1E_0F));
      a_dly = 0; b_dly = 0;

      // Case 4: overflow on row 2 only.
      for (int i = 0; i < VL; i++) begin
         xv[i] = 127;
         Wm[0][i] = 0; Wm[1][i] = (i == 0) ? 1 : 0; Wm[2][i] = 127;
         Wm[3][i] = (i == 0) ? 1 : ((i == 1) ? -1 : 0);
      end
      load_rom();
      run_vec("c4", 0);
      chk("c4_err", 64'(out_error), 64'(1));
      chk("c4_rows", 64'({out_vector[31:24], out_vector[15:0]}), 64'(24'h00_7F_00));

      // Case 5: long output back-pressure, then a second vector.
      set_case1();
      run_vec("c5a", 10);
      for (int i = 0; i < VL; i++) xv[i] = 5 - i;
      run_vec("c5b", 0);

      // Case 6: reset while collecting row 1.
      set_case1();
      r_dly = 5;
      @(negedge clk);
      drive_x();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!(mac_result_ready && w_addr == 3'd1) && n < 500) begin @(negedge clk); n++; end
      chk("c6_reach_collect1", 64'({mac_result_ready, w_addr}), 64'({1'b1, 3'd1}));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("c6_after_rst", 64'({in_ready, out_valid, mac_result_ready, mac_a_valid, mac_b_valid}),
          64'(5'b10000));
      n = 0;
      repeat (5) begin @(negedge clk); if (out_valid) n++; end
      chk("c6_no_partial", 64'(n), 64'(0));
      r_dly = 0;
      run_vec("c6_rerun", 0);
      chk("c6_const", 64'(out_vector), 64'(32'h00_01_1E_0F));

      // Randomized vectors, weights and handshake timing.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < VL; i++) begin
            xv[i] = int'($urandom_range(255)) - 128;
            for (int r = 0; r < ROWS; r++)
               Wm[r][i] = (t < 4) ? int'($urandom_range(10)) - 5 : int'($urandom_range(255)) - 128;
         end
         load_rom();
         a_dly = int'($urandom_range(4));
         b_dly = int'($urandom_range(4));
         r_dly = int'($urandom_range(3));
         run_vec($sformatf("rnd%0d", t), int'($urandom_range(3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
